fpu_div: RTL

Multicycle IEEE-754 single-precision floating-point divider, the inverse of the combinational FPU multiplier path. It computes Operand1 / Operand2 with a radix-2 restoring mantissa divider, one quotient bit per cycle. It sits beside the FPU in the execute stage. Its Start/Busy handshake matches the MCycle unit, so the core stalls while Busy is high.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fp_unpack.sv | 26 ++
 rtl/fpu_div.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 special encodings, divider FSM states and
// operand classes used by fp_unpack and the multicycle divider.
package fpu_pkg;

    localparam logic [31:0] FP_NAN     = 32'hFFFF_FFFF;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
    localparam logic [9:0]  FP_BIAS    = 10'd127;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] NORM = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [1:0] CLS_ZERO   = 2'd0;
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_INF    = 2'd2;
    localparam logic [1:0] CLS_NAN    = 2'd3;

endpackage

// File: rtl/fp_unpack.sv
// Splits a binary32 value into sign, exponent, 24-bit mantissa (hidden 1 made
// explicit) and an operand class; denormals are flushed to zero.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0] fp,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output logic [1:0]  cls
);

    always_comb begin
        sign = fp[31];
        exp  = fp[30:23];
        mant = {1'b1, fp[22:0]};
        cls  = CLS_NORMAL;
        if (fp[30:23] == 8'h00) begin
            mant = '0;
            cls  = CLS_ZERO;
        end else if (fp[30:23] == 8'hFF) begin
            cls = (fp[22:0] == 23'h0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fpu_div.sv
// Multicycle binary32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, truncating rounding, Start/Busy/Done handshake.
module fpu_div
    import fpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    output logic [31:0] Result,
    output logic        Busy,
    output logic        Done
);

    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [1:0]  cls_a, cls_b;

    fp_unpack u_unpack_a (.fp(Operand1), .sign(sign_a), .exp(exp_a), .mant(mant_a), .cls(cls_a));
    fp_unpack u_unpack_b (.fp(Operand2), .sign(sign_b), .exp(exp_b), .mant(mant_b), .cls(cls_b));

    logic [1:0]        state;
    logic [25:0]       r;
    logic [23:0]       d;
    logic [24:0]       q;
    logic signed [9:0] e;
    logic              s;
    logic [4:0]        cnt;
    logic [31:0]       fin_res;

    // Special-case classification of the live operands, valid while IDLE
    logic        is_special;
    logic [31:0] special_res;
    logic        s_in;

    always_comb begin
        s_in        = sign_a ^ sign_b;
        is_special  = 1'b1;
        special_res = FP_NAN;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            special_res = FP_NAN;
        end else if (cls_b == CLS_ZERO || cls_a == CLS_INF) begin
            special_res = s_in ? FP_NEG_INF : FP_POS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            special_res = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    logic        q_bit;
    logic [25:0] r_sub;
    logic [25:0] r_next;

    always_comb begin
        q_bit  = (r >= {2'b00, d});
        r_sub  = q_bit ? (r - {2'b00, d}) : r;
        r_next = r_sub << 1;
    end

    logic signed [9:0] e_fin;
    logic [22:0]       m_fin;
    logic [31:0]       norm_res;

    always_comb begin
        if (q[24]) begin
            m_fin = q[23:1];
            e_fin = e;
        end else begin
            m_fin = q[22:0];
            e_fin = e - 10'sd1;
        end
        if (e_fin >= 10'sd255) begin
            norm_res = s ? FP_NEG_INF : FP_POS_INF;
        end else if (e_fin <= 10'sd0) begin
            norm_res = '0;
        end else begin
            norm_res = {s, e_fin[7:0], m_fin};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            Result  <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            r       <= '0;
            d       <= '0;
            q       <= '0;
            e       <= '0;
            s       <= 1'b0;
            cnt     <= '0;
            fin_res <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        Busy <= 1'b1;
                        s    <= s_in;
                        if (is_special) begin
                            fin_res <= special_res;
                            state   <= FIN;
                        end else begin
                            r     <= {2'b00, mant_a};
                            d     <= mant_b;
                            q     <= '0;
                            // Modular 10-bit arithmetic yields the signed biased exponent
                            e     <= {2'b00, exp_a} - {2'b00, exp_b} + FP_BIAS;
                            cnt   <= 5'd24;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    r   <= r_next;
                    q   <= {q[23:0], q_bit};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    Result <= norm_res;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
                FIN: begin
                    Result <= fin_res;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
